// File: rtl/conv_enc_tx_if.sv
// Handshake bundle for the rate-1/2 encoder: serial bit input stream and
// 2-bit code symbol output stream.
interface conv_enc_tx_if;
  logic       in_valid;
  logic       in_ready;
  logic       in_bit;
  logic       in_last;
  logic       out_valid;
  logic       out_ready;
  logic [1:0] out_sym;
  logic       out_last;

  modport master (
    output in_valid, in_bit, in_last, out_ready,
    input  in_ready, out_valid, out_sym, out_last
  );

  modport slave (
    input  in_valid, in_bit, in_last, out_ready,
    output in_ready, out_valid, out_sym, out_last
  );
endinterface

// File: rtl/conv_enc_tx.sv
// Rate-1/2 convolutional encoder with per-frame zero-tail termination so
// the trellis always returns to state 0 for the decoder's traceback.
module conv_enc_tx #(
  parameter int           K  = 3,
  parameter logic [K-1:0] G0 = 3'b111,
  parameter logic [K-1:0] G1 = 3'b101
) (
  input  logic          clk,
  input  logic          rst,
  conv_enc_tx_if.slave  bus,
  output logic [1:0]    s_cur,
  output logic          busy
);

  localparam int TW = $clog2(K);
  localparam logic [TW-1:0] TLAST = TW'(K - 2);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    DATA = 2'b01,
    TAIL = 2'b10
  } state_t;

  state_t        state;
  logic [K-2:0]  sr;
  logic [TW-1:0] tcnt;
  logic          out_valid_q;
  logic [1:0]    out_sym_q;
  logic          out_last_q;

  logic          out_free;
  logic          in_fire;
  logic          tail_load;
  logic          b;
  logic [K-1:0]  v;
  logic [1:0]    sym;

  // The output register can take a new symbol when empty or draining this cycle.
  assign out_free  = !out_valid_q || bus.out_ready;
  assign in_fire   = bus.in_valid && bus.in_ready;
  assign tail_load = (state == TAIL) && out_free;
  assign b         = (state == TAIL) ? 1'b0 : bus.in_bit;
  assign v         = {b, sr};
  assign sym       = {^(v & G0), ^(v & G1)};

  assign bus.in_ready  = !rst && (state != TAIL) && out_free;
  assign bus.out_valid = out_valid_q;
  assign bus.out_sym   = out_sym_q;
  assign bus.out_last  = out_last_q;
  assign s_cur         = state;
  assign busy          = (state != IDLE) || out_valid_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      sr          <= '0;
      tcnt        <= '0;
      out_valid_q <= 1'b0;
      out_sym_q   <= 2'b00;
      out_last_q  <= 1'b0;
    end else begin
      if (in_fire || tail_load) begin
        out_sym_q   <= sym;
        out_valid_q <= 1'b1;
        out_last_q  <= tail_load && (tcnt == TLAST);
        // Shifting v right by one drops the oldest bit and keeps b as the newest.
        sr          <= v[K-1:1];
      end else if (bus.out_ready) begin
        out_valid_q <= 1'b0;
        out_last_q  <= 1'b0;
      end

      case (state)
        IDLE, DATA: begin
          if (in_fire) begin
            state <= bus.in_last ? TAIL : DATA;
          end
        end
        TAIL: begin
          if (out_free) begin
            if (tcnt == TLAST) begin
              tcnt  <= '0;
              state <= IDLE;
            end else begin
              tcnt <= tcnt + 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
